// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - one requester port of the shared-memory arbiter
interface mem_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  valid;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  ready;
   logic                  rvalid;
   logic [DATA_WIDTH-1:0] rdata;

   modport master (
      output valid, we, addr, wdata,
      input  ready, rvalid, rdata
   );

   modport slave (
      input  valid, we, addr, wdata,
      output ready, rvalid, rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one single-port synchronous memory
// between two requesters (m0 = CPU load/store, m1 = loader/debug).
module mem_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   mem_arbiter_if.slave          m0,
   mem_arbiter_if.slave          m1,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t                state;
   logic                  gnt;
   logic                  last;
   logic                  sel_valid;
   logic                  sel_we;
   logic                  other_valid;
   logic                  issue;
   logic                  resp;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   // Tie goes to the requester that was not served last.
   function automatic logic pick(input logic v0, input logic v1, input logic prev);
      return (v0 && v1) ? ~prev : v1;
   endfunction

   assign sel_valid   = gnt ? m1.valid : m0.valid;
   assign sel_we      = gnt ? m1.we    : m0.we;
   assign sel_addr    = gnt ? m1.addr  : m0.addr;
   assign sel_wdata   = gnt ? m1.wdata : m0.wdata;
   assign other_valid = gnt ? m0.valid : m1.valid;

   // Issue qualifies on the live valid so a dropped request aborts without a strobe.
   assign issue = (state == ISSUE) && sel_valid;
   assign resp  = (state == RESP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         gnt   <= 1'b0;
         last  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (m0.valid || m1.valid) begin
                  gnt   <= pick(m0.valid, m1.valid, last);
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               if (!sel_valid) begin
                  state <= IDLE;
               end else begin
                  last <= gnt;
                  if (!sel_we) begin
                     state <= RESP;
                  end else if (other_valid) begin
                     // The accepted write is consumed, so only the other side can be regranted.
                     gnt <= ~gnt;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            RESP: begin
               if (m0.valid || m1.valid) begin
                  gnt   <= pick(m0.valid, m1.valid, last);
                  state <= ISSUE;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign mem_en    = issue;
   assign mem_we    = issue && sel_we;
   assign mem_addr  = issue ? sel_addr  : '0;
   assign mem_wdata = issue ? sel_wdata : '0;

   assign m0.ready  = issue && !gnt;
   assign m1.ready  = issue && gnt;
   assign m0.rvalid = resp && !gnt;
   assign m1.rvalid = resp && gnt;
   assign m0.rdata  = (resp && !gnt) ? mem_rdata : '0;
   assign m1.rdata  = (resp && gnt)  ? mem_rdata : '0;
endmodule
